// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports and the data-memory bus
// seen by mem_arbiter.
//   slave  modport : arbiter view (requests + mem_rData in; grants, dones,
//                    read data, busy and memory strobes out)
//   master modport : environment view (requesters and the memory itself)
// Requester signals : req*, rw*, addr*, wdata* -> gnt*, done*, rdata*
// Memory signals    : mem_enable, mem_rw, mem_add, mem_wData -> mem_rData
interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              rw0;
  logic              rw1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic              mem_enable;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_add;
  logic [DATA_W-1:0] mem_wData;
  logic [DATA_W-1:0] mem_rData;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_rData,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
           mem_enable, mem_rw, mem_add, mem_wData
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_rData,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
           mem_enable, mem_rw, mem_add, mem_wData
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port data memory
// between port 0 (control unit) and port 1 (loader/DMA master).
// Each access: IDLE (request sampled) -> ACCESS (gnt + mem_enable, one
// cycle) -> WAIT (MEM_LAT cycles) -> back to IDLE with the done pulse.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : mem_arbiter_if.slave (requester handshakes and memory bus)
// All outputs are registered.
module mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1     // 1..15
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  logic [1:0]        r_state;
  logic              r_last;     // port granted last; loser of the next tie
  logic              r_sel;      // port owning the current access
  logic [3:0]        r_cnt;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_done0;
  logic              r_done1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_busy;
  logic              r_mem_enable;
  logic              r_mem_rw;   // also remembers read/write through WAIT
  logic [ADDR_W-1:0] r_mem_add;
  logic [DATA_W-1:0] r_mem_wData;

  logic              w_any;
  logic              w_pick;

  always_comb begin
    w_any  = bus.req0 | bus.req1;
    // Tie goes to the port that was not granted last; otherwise the lone requester.
    w_pick = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_sel        <= 1'b0;
      r_cnt        <= '0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_busy       <= 1'b0;
      r_mem_enable <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_add    <= '0;
      r_mem_wData  <= '0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_mem_enable <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel        <= w_pick;
            r_mem_rw     <= w_pick ? bus.rw1    : bus.rw0;
            r_mem_add    <= w_pick ? bus.addr1  : bus.addr0;
            r_mem_wData  <= w_pick ? bus.wdata1 : bus.wdata0;
            r_mem_enable <= 1'b1;
            r_gnt0       <= ~w_pick;
            r_gnt1       <= w_pick;
            r_busy       <= 1'b1;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          r_cnt   <= LAT_M1;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_mem_rw) begin
              if (r_sel) r_rdata1 <= bus.mem_rData;
              else       r_rdata0 <= bus.mem_rData;
            end
            r_done0 <= ~r_sel;
            r_done1 <= r_sel;
            r_last  <= r_sel;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0       = r_gnt0;
  assign bus.gnt1       = r_gnt1;
  assign bus.done0      = r_done0;
  assign bus.done1      = r_done1;
  assign bus.rdata0     = r_rdata0;
  assign bus.rdata1     = r_rdata1;
  assign bus.busy       = r_busy;
  assign bus.mem_enable = r_mem_enable;
  assign bus.mem_rw     = r_mem_rw;
  assign bus.mem_add    = r_mem_add;
  assign bus.mem_wData  = r_mem_wData;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Stimulus pushes the
// expected gnt/done events (with cycle, address and data) into a queue;
// a negedge monitor pops and compares whenever a DUT shows gnt or done.
// dutA runs with MEM_LAT=1, dutB with MEM_LAT=3, each with its own memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) busA ();
  mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) busB ();

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1)) dutA (
    .clk(clk), .reset(reset), .bus(busA));
  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3)) dutB (
    .clk(clk), .reset(reset), .bus(busB));

  // Memory A: read data valid one cycle after the enable is sampled.
  logic [31:0] memA [1024];
  logic [31:0] rdA;
  assign busA.mem_rData = rdA;
  initial begin
    foreach (memA[i]) memA[i] = '0;
    memA[10'h005] = 32'hDEADBEEF;
    memA[10'h010] = 32'hA0A00010;
    memA[10'h020] = 32'hB0B00020;
    for (int k = 0; k < 4; k++) memA[10'h100 + k] = 32'h11110000 + k;
    rdA = '0;
    forever begin
      @(posedge clk);
      if (busA.mem_enable === 1'b1) begin
        if (busA.mem_rw) memA[busA.mem_add] <= busA.mem_wData;
        else             rdA <= memA[busA.mem_add];
      end
    end
  end

  // Memory B: three-stage read pipeline.
  logic [31:0] memB [1024];
  logic [31:0] pipeB [3];
  assign busB.mem_rData = pipeB[2];
  initial begin
    foreach (memB[i]) memB[i] = '0;
    memB[10'h0A0] = 32'h0000CAFE;
    foreach (pipeB[i]) pipeB[i] = '0;
    forever begin
      @(posedge clk);
      pipeB[2] <= pipeB[1];
      pipeB[1] <= pipeB[0];
      pipeB[0] <= '0;
      if (busB.mem_enable === 1'b1) begin
        if (busB.mem_rw) memB[busB.mem_add] <= busB.mem_wData;
        else             pipeB[0] <= memB[busB.mem_add];
      end
    end
  end

  typedef struct {
    int          dut;
    int          kind;   // 0 = gnt, 1 = done
    int          port;
    int          cyc;
    logic        rw;
    logic [9:0]  addr;
    logic [31:0] data;   // gnt: write data; done: expected rdata of the port
  } exp_t;

  exp_t sb[$];

  task automatic expect_ev(input int dut, input int kind, input int port, input int c,
                           input logic rw, input logic [9:0] addr, input logic [31:0] data);
    exp_t e;
    e.dut = dut; e.kind = kind; e.port = port; e.cyc = c;
    e.rw = rw; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [3:0]  ev;
    logic        en, mrw;
    logic [9:0]  ad;
    logic [31:0] wd, rd0, rd1;
    exp_t        e;
    int          kind, port;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_event: dut %0d kind %0d port %0d due cycle %0d, none by cycle %0d",
               sb[0].dut, sb[0].kind, sb[0].port, sb[0].cyc, cyc);
      sb.delete(0);
    end
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        ev = {busA.done1, busA.done0, busA.gnt1, busA.gnt0};
        en = busA.mem_enable; mrw = busA.mem_rw; ad = busA.mem_add;
        wd = busA.mem_wData; rd0 = busA.rdata0; rd1 = busA.rdata1;
      end else begin
        ev = {busB.done1, busB.done0, busB.gnt1, busB.gnt0};
        en = busB.mem_enable; mrw = busB.mem_rw; ad = busB.mem_add;
        wd = busB.mem_wData; rd0 = busB.rdata0; rd1 = busB.rdata1;
      end
      if (ev != 4'b0000) begin
        if ($countones(ev) != 1) begin
          checks++; errors++;
          $display("FAIL multi_event: dut %0d got %b expected one-hot", d, ev);
        end else if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: dut %0d got %b expected none (cycle %0d)", d, ev, cyc);
        end else begin
          e = sb[0];
          sb.delete(0);
          kind = (ev[3] | ev[2]) ? 1 : 0;
          port = (ev[3] | ev[1]) ? 1 : 0;
          chk("event_dut",   d,    e.dut);
          chk("event_kind",  kind, e.kind);
          chk("event_port",  port, e.port);
          chk("event_cycle", cyc,  e.cyc);
          if (e.kind == 0) begin
            chk("gnt_mem_enable", {31'b0, en},  32'd1);
            chk("gnt_mem_rw",     {31'b0, mrw}, {31'b0, e.rw});
            chk("gnt_mem_add",    {22'b0, ad},  {22'b0, e.addr});
            if (e.rw) chk("gnt_mem_wData", wd, e.data);
          end else begin
            chk("done_rdata", e.port ? rd1 : rd0, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_zero_A(input string tag);
    chk({tag, "_gnt0"},       {31'b0, busA.gnt0},       '0);
    chk({tag, "_gnt1"},       {31'b0, busA.gnt1},       '0);
    chk({tag, "_done0"},      {31'b0, busA.done0},      '0);
    chk({tag, "_done1"},      {31'b0, busA.done1},      '0);
    chk({tag, "_busy"},       {31'b0, busA.busy},       '0);
    chk({tag, "_mem_enable"}, {31'b0, busA.mem_enable}, '0);
    chk({tag, "_mem_rw"},     {31'b0, busA.mem_rw},     '0);
    chk({tag, "_mem_add"},    {22'b0, busA.mem_add},    '0);
    chk({tag, "_mem_wData"},  busA.mem_wData,           '0);
    chk({tag, "_rdata0"},     busA.rdata0,              '0);
    chk({tag, "_rdata1"},     busA.rdata1,              '0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int t0, t1;
    reset = 1'b1;
    {busA.req0, busA.req1, busA.rw0, busA.rw1} = '0;
    {busA.addr0, busA.addr1, busA.wdata0, busA.wdata1} = '0;
    {busB.req0, busB.req1, busB.rw0, busB.rw1} = '0;
    {busB.addr0, busB.addr1, busB.wdata0, busB.wdata1} = '0;
    tick(); tick();
    @(negedge clk);
    check_zero_A("reset");

    // 1: single read on port 0
    do_reset();
    t0 = cyc;
    expect_ev(0, 0, 0, t0 + 1, 1'b0, 10'h005, '0);
    expect_ev(0, 1, 0, t0 + 3, 1'b0, 10'h005, 32'hDEADBEEF);
    busA.req0 = 1'b1; busA.rw0 = 1'b0; busA.addr0 = 10'h005;
    tick();
    busA.req0 = 1'b0;
    wait_until(t0 + 6);

    // 2: port 0 write, then port 1 reads it back
    do_reset();
    t0 = cyc;
    expect_ev(0, 0, 0, t0 + 1, 1'b1, 10'h3FF, 32'h12345678);
    expect_ev(0, 1, 0, t0 + 3, 1'b1, 10'h3FF, 32'h0);
    expect_ev(0, 0, 1, t0 + 4, 1'b0, 10'h3FF, '0);
    expect_ev(0, 1, 1, t0 + 6, 1'b0, 10'h3FF, 32'h12345678);
    busA.req0 = 1'b1; busA.rw0 = 1'b1; busA.addr0 = 10'h3FF; busA.wdata0 = 32'h12345678;
    tick();
    busA.req0 = 1'b0; busA.rw0 = 1'b0;
    busA.req1 = 1'b1; busA.rw1 = 1'b0; busA.addr1 = 10'h3FF;
    wait_until(t0 + 5);
    busA.req1 = 1'b0;
    wait_until(t0 + 9);
    @(negedge clk);
    chk("write_keeps_rdata0", busA.rdata0, 32'h0);

    // 3: both ports held high -> strict alternation 0,1,0,1
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      expect_ev(0, 0, k % 2, t0 + 1 + 3 * k, 1'b0, (k % 2) ? 10'h020 : 10'h010, '0);
      expect_ev(0, 1, k % 2, t0 + 3 + 3 * k, 1'b0, '0,
                (k % 2) ? 32'hB0B00020 : 32'hA0A00010);
    end
    busA.req0 = 1'b1; busA.addr0 = 10'h010;
    busA.req1 = 1'b1; busA.addr1 = 10'h020;
    wait_until(t0 + 8);
    busA.req0 = 1'b0;
    wait_until(t0 + 11);
    busA.req1 = 1'b0;
    wait_until(t0 + 15);

    // 4: port 1 alone, back-to-back, new address after each grant
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      expect_ev(0, 0, 1, t0 + 1 + 3 * k, 1'b0, 10'(10'h100 + k), '0);
      expect_ev(0, 1, 1, t0 + 3 + 3 * k, 1'b0, '0, 32'h11110000 + k);
    end
    busA.req1 = 1'b1; busA.rw1 = 1'b0; busA.addr1 = 10'h100;
    for (int k = 0; k < 3; k++) begin
      wait_until(t0 + 2 + 3 * k);
      busA.addr1 = 10'(10'h101 + k);
    end
    wait_until(t0 + 11);
    busA.req1 = 1'b0;
    wait_until(t0 + 15);

    // 5: reset during WAIT aborts the read silently
    do_reset();
    t0 = cyc;
    expect_ev(0, 0, 0, t0 + 1, 1'b0, 10'h005, '0);
    busA.req0 = 1'b1; busA.rw0 = 1'b0; busA.addr0 = 10'h005;
    tick();
    busA.req0 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_zero_A("abort");
    tick();
    reset = 1'b0;
    t1 = cyc;
    expect_ev(0, 0, 0, t1 + 1, 1'b0, 10'h005, '0);
    expect_ev(0, 1, 0, t1 + 3, 1'b0, 10'h005, 32'hDEADBEEF);
    busA.req0 = 1'b1;
    tick();
    busA.req0 = 1'b0;
    wait_until(t1 + 6);

    // 6: MEM_LAT = 3 instance
    do_reset();
    t0 = cyc;
    expect_ev(1, 0, 0, t0 + 1, 1'b0, 10'h0A0, '0);
    expect_ev(1, 1, 0, t0 + 5, 1'b0, 10'h0A0, 32'h0000CAFE);
    busB.req0 = 1'b1; busB.rw0 = 1'b0; busB.addr0 = 10'h0A0;
    @(negedge clk);
    chk("lat3_busy_c0", {31'b0, busB.busy}, '0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) busB.req0 = 1'b0;
      @(negedge clk);
      chk($sformatf("lat3_busy_c%0d", c), {31'b0, busB.busy}, (c <= 4) ? 32'd1 : 32'd0);
    end
    wait_until(t0 + 9);

    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing_event: dut %0d kind %0d port %0d due cycle %0d, still pending at end of run",
               sb[0].dut, sb[0].kind, sb[0].port, sb[0].cyc);
      sb.delete(0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
